// File: rtl/vc_read_scheduler_if.sv
// Handshake bundle between the VC buffers / crossbar mux and the read scheduler.
// master: buffer/status side, slave: scheduler side.
interface vc_read_scheduler_if #(
    parameter int VC_NUM = 2,
    parameter int SEL_W  = $clog2(VC_NUM)
);
    logic [VC_NUM-1:0]      vc_empty_i;
    logic [VC_NUM-1:0][1:0] vc_flit_type_i;
    logic                   out_on_i;
    logic [VC_NUM-1:0]      vc_read_o;
    logic [SEL_W-1:0]       vc_sel_o;
    logic                   valid_o;
    logic                   locked_o;
    logic                   err_o;

    modport master (
        output vc_empty_i, vc_flit_type_i, out_on_i,
        input  vc_read_o, vc_sel_o, valid_o, locked_o, err_o
    );

    modport slave (
        input  vc_empty_i, vc_flit_type_i, out_on_i,
        output vc_read_o, vc_sel_o, valid_o, locked_o, err_o
    );
endinterface

// File: rtl/vc_read_scheduler.sv
// Wormhole VC read scheduler: packet-granular round-robin among VC buffers of one
// input port, holding the port for the winning VC until its TAIL flit is read.
module vc_read_scheduler #(
    parameter int VC_NUM = 2,
    parameter int SEL_W  = $clog2(VC_NUM)
) (
    input logic               clk,
    input logic               rst,
    vc_read_scheduler_if.slave bus
);

    localparam logic [1:0] FT_HEAD = 2'b00;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic             err_q, err_d;

    logic [VC_NUM-1:0] eligible;
    logic [VC_NUM-1:0] bad_type;
    logic [VC_NUM-1:0] read;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  cand;
    logic              found;
    logic [1:0]        owner_type;
    logic              owner_empty;

    // Explicit wrap so non-power-of-2 VC counts stay in range.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] x);
        return (x == SEL_W'(VC_NUM - 1)) ? '0 : x + 1'b1;
    endfunction

    for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
        assign eligible[i] = ~bus.vc_empty_i[i] &
                             ((bus.vc_flit_type_i[i] == FT_HEAD) || (bus.vc_flit_type_i[i] == FT_HT));
        assign bad_type[i] = ~bus.vc_empty_i[i] &
                             ((bus.vc_flit_type_i[i] == FT_BODY) || (bus.vc_flit_type_i[i] == FT_TAIL));
    end

    assign owner_type  = bus.vc_flit_type_i[owner_q];
    assign owner_empty = bus.vc_empty_i[owner_q];

    // First eligible VC scanning from rr_ptr with wrap.
    always_comb begin
        found = 1'b0;
        grant = rr_ptr_q;
        cand  = rr_ptr_q;
        for (int k = 0; k < VC_NUM; k++) begin
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        err_d    = err_q;
        read     = '0;
        sel      = rr_ptr_q;
        if (state_q == IDLE) begin
            if (|bad_type) err_d = 1'b1;
            if (found && bus.out_on_i) begin
                read[grant] = 1'b1;
                sel         = grant;
                if (bus.vc_flit_type_i[grant] == FT_HEAD) begin
                    state_d = LOCKED;
                    owner_d = grant;
                end else begin
                    rr_ptr_d = wrap_inc(grant);
                end
            end
        end else begin
            sel = owner_q;
            if (!owner_empty) begin
                if ((owner_type == FT_BODY) || (owner_type == FT_TAIL)) begin
                    if (bus.out_on_i) begin
                        read[owner_q] = 1'b1;
                        if (owner_type == FT_TAIL) begin
                            state_d  = IDLE;
                            rr_ptr_d = wrap_inc(owner_q);
                        end
                    end
                end else begin
                    // A header inside a packet: never read it, so the port stalls until reset.
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

    assign bus.vc_read_o = rst ? read : '0;
    assign bus.vc_sel_o  = rst ? sel : '0;
    assign bus.valid_o   = rst & (|read);
    assign bus.locked_o  = rst & (state_q == LOCKED);
    assign bus.err_o     = rst & err_q;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Directed bench for vc_read_scheduler with VC_NUM = 2, 3 and 4 instances.
module tb_vc_read_scheduler;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    vc_read_scheduler_if #(.VC_NUM(2)) b2 ();
    vc_read_scheduler_if #(.VC_NUM(3)) b3 ();
    vc_read_scheduler_if #(.VC_NUM(4)) b4 ();

    vc_read_scheduler #(.VC_NUM(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
    vc_read_scheduler #(.VC_NUM(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
    vc_read_scheduler #(.VC_NUM(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv2(input logic [1:0] e, input logic [3:0] t, input logic on);
        b2.vc_empty_i = e; b2.vc_flit_type_i = t; b2.out_on_i = on;
        #1;
    endtask

    task automatic drv3(input logic [2:0] e, input logic [5:0] t, input logic on);
        b3.vc_empty_i = e; b3.vc_flit_type_i = t; b3.out_on_i = on;
        #1;
    endtask

    task automatic drv4(input logic [3:0] e, input logic [7:0] t, input logic on);
        b4.vc_empty_i = e; b4.vc_flit_type_i = t; b4.out_on_i = on;
        #1;
    endtask

    task automatic e2(input string tag, input logic [1:0] rd, input logic sel, input logic lck);
        chk({tag, "_rd"}, b2.vc_read_o, rd);
        chk({tag, "_sel"}, b2.vc_sel_o, sel);
        chk({tag, "_vld"}, b2.valid_o, |rd);
        chk({tag, "_lck"}, b2.locked_o, lck);
    endtask

    task automatic e3(input string tag, input logic [2:0] rd, input logic [1:0] sel, input logic lck);
        chk({tag, "_rd"}, b3.vc_read_o, rd);
        chk({tag, "_sel"}, b3.vc_sel_o, sel);
        chk({tag, "_vld"}, b3.valid_o, |rd);
        chk({tag, "_lck"}, b3.locked_o, lck);
    endtask

    task automatic e4(input string tag, input logic [3:0] rd, input logic [1:0] sel, input logic lck);
        chk({tag, "_rd"}, b4.vc_read_o, rd);
        chk({tag, "_sel"}, b4.vc_sel_o, sel);
        chk({tag, "_vld"}, b4.valid_o, |rd);
        chk({tag, "_lck"}, b4.locked_o, lck);
    endtask

    initial begin
        rst = 1'b0;
        b2.vc_empty_i = '1; b2.vc_flit_type_i = '0; b2.out_on_i = 1'b0;
        b3.vc_empty_i = '1; b3.vc_flit_type_i = '0; b3.out_on_i = 1'b0;
        b4.vc_empty_i = '1; b4.vc_flit_type_i = '0; b4.out_on_i = 1'b0;

        // reset holds all outputs low even with readable flits present
        for (int n = 0; n < 3; n++) begin
            b2.vc_empty_i = '0; b2.out_on_i = 1'b1;
            b2.vc_flit_type_i = (n == 0) ? 4'hF : 4'($urandom);
            b4.vc_empty_i = 4'($urandom); b4.out_on_i = 1'b1;
            b4.vc_flit_type_i = (n == 0) ? 8'hFF : 8'($urandom);
            #3;
            e2("rst2", 2'b00, 1'b0, 1'b0);
            chk("rst2_err", b2.err_o, 1'b0);
            e4("rst4", 4'b0000, 2'd0, 1'b0);
            chk("rst4_err", b4.err_o, 1'b0);
        end
        drv2(2'b11, 4'h0, 1'b1);
        drv3(3'b111, 6'h0, 1'b1);
        drv4(4'b1111, 8'h0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        e2("rel", 2'b00, 1'b0, 1'b0);
        chk("rel_err", b2.err_o, 1'b0);
        cyc();

        // single 4-flit packet on VC1
        drv2(2'b01, 4'b0000, 1'b1); e2("p_h", 2'b10, 1'b1, 1'b0); cyc();
        drv2(2'b01, 4'b0100, 1'b1); e2("p_b1", 2'b10, 1'b1, 1'b1); cyc();
        drv2(2'b01, 4'b0100, 1'b1); e2("p_b2", 2'b10, 1'b1, 1'b1); cyc();
        drv2(2'b01, 4'b1000, 1'b1); e2("p_t", 2'b10, 1'b1, 1'b1); cyc();
        drv2(2'b11, 4'b0000, 1'b1); e2("p_end", 2'b00, 1'b0, 1'b0);
        drv2(2'b00, 4'b1111, 1'b1); e2("p_ht0", 2'b01, 1'b0, 1'b0); cyc();
        drv2(2'b00, 4'b1111, 1'b1); e2("p_ht1", 2'b10, 1'b1, 1'b0); cyc();

        // wormhole hold: VC0 owns the port while empty, VC1 waits
        drv2(2'b10, 4'b0000, 1'b1); e2("w_h", 2'b01, 1'b0, 1'b0); cyc();
        for (int n = 0; n < 3; n++) begin
            drv2(2'b01, 4'b0000, 1'b1); e2("w_hold", 2'b00, 1'b0, 1'b1);
            chk("w_err", b2.err_o, 1'b0);
            cyc();
        end
        drv2(2'b00, 4'b0001, 1'b1); e2("w_b", 2'b01, 1'b0, 1'b1); cyc();
        drv2(2'b00, 4'b0010, 1'b1); e2("w_t", 2'b01, 1'b0, 1'b1); cyc();
        drv2(2'b01, 4'b0000, 1'b1); e2("w_v1h", 2'b10, 1'b1, 1'b0); cyc();
        drv2(2'b01, 4'b1000, 1'b1); e2("w_v1t", 2'b10, 1'b1, 1'b1); cyc();

        // flow control mid-packet
        drv2(2'b10, 4'b0000, 1'b1); e2("f_h", 2'b01, 1'b0, 1'b0); cyc();
        for (int n = 0; n < 2; n++) begin
            drv2(2'b10, 4'b0001, 1'b0); e2("f_off", 2'b00, 1'b0, 1'b1); cyc();
        end
        drv2(2'b10, 4'b0001, 1'b1); e2("f_b", 2'b01, 1'b0, 1'b1); cyc();
        drv2(2'b10, 4'b0010, 1'b1); e2("f_t", 2'b01, 1'b0, 1'b1); cyc();
        drv2(2'b10, 4'b0011, 1'b0); e2("f_idle_off", 2'b00, 1'b1, 1'b0); cyc();
        drv2(2'b10, 4'b0011, 1'b1); e2("f_idle_on", 2'b01, 1'b0, 1'b0); cyc();
        drv2(2'b11, 4'b0000, 1'b1);

        // round-robin with VC_NUM=4
        for (int g = 0; g < 5; g++) begin
            drv4(4'b0000, 8'hFF, 1'b1);
            e4("rr4", 4'(1 << (g % 4)), 2'(g % 4), 1'b0);
            cyc();
        end
        drv4(4'b0110, 8'hFF, 1'b1); e4("rr4_skip", 4'b1000, 2'd3, 1'b0); cyc();
        drv4(4'b0110, 8'hFF, 1'b1); e4("rr4_wrap", 4'b0001, 2'd0, 1'b0); cyc();
        // header seen inside a packet: flagged and stalled
        drv4(4'b1101, 8'h00, 1'b1); e4("lk_h", 4'b0010, 2'd1, 1'b0); cyc();
        drv4(4'b1101, 8'h00, 1'b1); e4("lk_bad", 4'b0000, 2'd1, 1'b1);
        chk("lk_err0", b4.err_o, 1'b0);
        cyc();
        drv4(4'b1101, 8'h00, 1'b1); e4("lk_stall", 4'b0000, 2'd1, 1'b1);
        chk("lk_err1", b4.err_o, 1'b1);
        drv4(4'b1111, 8'h00, 1'b1);

        // non-power-of-2 wrap with VC_NUM=3
        for (int g = 0; g < 4; g++) begin
            drv3(3'b000, 6'h3F, 1'b1);
            e3("rr3", 3'(1 << (g % 3)), 2'(g % 3), 1'b0);
            cyc();
        end
        drv3(3'b011, 6'b000000, 1'b1); e3("v3_h", 3'b100, 2'd2, 1'b0); cyc();
        drv3(3'b011, 6'b100000, 1'b1); e3("v3_t", 3'b100, 2'd2, 1'b1); cyc();
        drv3(3'b000, 6'h3F, 1'b1); e3("v3_wrap", 3'b001, 2'd0, 1'b0); cyc();
        drv3(3'b111, 6'h00, 1'b1); e3("v3_ptr", 3'b000, 2'd1, 1'b0);

        // protocol error in IDLE and reset mid-packet
        drv2(2'b00, 4'b1101, 1'b1); e2("e_ht", 2'b10, 1'b1, 1'b0);
        chk("e_err0", b2.err_o, 1'b0);
        cyc();
        drv2(2'b00, 4'b1101, 1'b1); e2("e_skip0", 2'b10, 1'b1, 1'b0);
        chk("e_err1", b2.err_o, 1'b1);
        cyc();
        drv2(2'b01, 4'b0000, 1'b1); e2("e_h", 2'b10, 1'b1, 1'b0); cyc();
        drv2(2'b01, 4'b0100, 1'b1); e2("e_b", 2'b10, 1'b1, 1'b1);
        chk("e_err2", b2.err_o, 1'b1);
        rst = 1'b0;
        #1;
        e2("mid_rst", 2'b00, 1'b0, 1'b0);
        chk("mid_rst_err", b2.err_o, 1'b0);
        chk("mid_rst_err4", b4.err_o, 1'b0);
        chk("mid_rst_lck4", b4.locked_o, 1'b0);
        cyc();
        rst = 1'b1;
        #1;
        e2("post_rst", 2'b00, 1'b0, 1'b0);
        chk("post_rst_err", b2.err_o, 1'b0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
